// File: rtl/cplx_mult_seq.sv
// cplx_mult_seq: handshaked signed complex multiplier sharing one real multiplier.
// Define CPLX_MULT_GAUSS_EN for the 3-product (Gauss) schedule; default is 4 products.
module cplx_mult_seq #(
  parameter int DATA_W   = 8,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst,
  input  logic              op_val,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_1_re,
  input  logic [DATA_W-1:0] op_1_im,
  input  logic [DATA_W-1:0] op_2_re,
  input  logic [DATA_W-1:0] op_2_im,
  output logic              res_val,
  input  logic              res_ready,
  output logic [2*DATA_W:0] res_re,
  output logic [2*DATA_W:0] res_im,
  output logic              busy
);

  localparam int RES_W = 2*DATA_W + 1;
`ifdef CPLX_MULT_GAUSS_EN
  localparam int P     = 3;
  localparam int MUL_W = DATA_W + 1;
`else
  localparam int P     = 4;
  localparam int MUL_W = DATA_W;
`endif
  localparam int PROD_W = 2*MUL_W;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, COMPUTE, WAIT_RES} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [1:0]                drain_q, drain_d;
  logic signed [DATA_W-1:0]  ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic signed [RES_W-1:0]   res_re_q, res_re_d, res_im_q, res_im_d;
  logic signed [RES_W-1:0]   part_q [P];
  logic signed [RES_W-1:0]   part_d [P];
  logic signed [PROD_W-1:0]  pp_q [MULT_LAT];
  logic signed [PROD_W-1:0]  pp_d [MULT_LAT];
  logic [1:0]                pt_q [MULT_LAT];
  logic [1:0]                pt_d [MULT_LAT];
  logic [MULT_LAT-1:0]       pv_q, pv_d;

  logic signed [MUL_W-1:0]   mul_a, mul_b;
  logic signed [PROD_W-1:0]  mul_p;
  logic                      accept;

  assign op_ready = (state_q == IDLE) || ((state_q == WAIT_RES) && res_ready);
  assign res_val  = (state_q == WAIT_RES);
  assign busy     = (state_q != IDLE);
  assign accept   = op_val && op_ready;
  assign res_re   = res_re_q;
  assign res_im   = res_im_q;

  // Operand selection for the shared multiplier, keyed by the issue index
  always_comb begin
    mul_a = '0;
    mul_b = '0;
`ifdef CPLX_MULT_GAUSS_EN
    case (idx_q)
      2'd0:    begin mul_a = MUL_W'(br_q); mul_b = MUL_W'(ar_q) + MUL_W'(ai_q); end
      2'd1:    begin mul_a = MUL_W'(ar_q); mul_b = MUL_W'(bi_q) - MUL_W'(br_q); end
      default: begin mul_a = MUL_W'(ai_q); mul_b = MUL_W'(br_q) + MUL_W'(bi_q); end
    endcase
`else
    case (idx_q)
      2'd0:    begin mul_a = ar_q; mul_b = br_q; end
      2'd1:    begin mul_a = ai_q; mul_b = bi_q; end
      2'd2:    begin mul_a = ar_q; mul_b = bi_q; end
      default: begin mul_a = ai_q; mul_b = br_q; end
    endcase
`endif
    mul_p = PROD_W'(mul_a) * PROD_W'(mul_b);
  end

  // Next-state: sequencer, product pipeline with tags, partial and result registers
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    ar_d     = ar_q;
    ai_d     = ai_q;
    br_d     = br_q;
    bi_d     = bi_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;
    part_d   = part_q;
    pp_d     = pp_q;
    pt_d     = pt_q;
    pv_d     = pv_q;

    pv_d[0] = (state_q == ISSUE);
    pt_d[0] = idx_q;
    pp_d[0] = mul_p;
    for (int unsigned i = 1; i < MULT_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pt_d[i] = pt_q[i-1];
      pp_d[i] = pp_q[i-1];
    end
    // Product sign-extended (Gauss: wrapped, exact modulo 2^RES_W) into its tagged slot
    if (pv_q[MULT_LAT-1]) begin
      part_d[pt_q[MULT_LAT-1]] = RES_W'(pp_q[MULT_LAT-1]);
    end

    if (accept) begin
      ar_d    = op_1_re;
      ai_d    = op_1_im;
      br_d    = op_2_re;
      bi_d    = op_2_im;
      idx_d   = '0;
      state_d = ISSUE;
    end else begin
      case (state_q)
        ISSUE: begin
          if (idx_q == 2'(P - 1)) begin
            idx_d   = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        DRAIN: begin
          if (drain_q == 2'(MULT_LAT - 1)) begin
            state_d = COMPUTE;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        COMPUTE: begin
`ifdef CPLX_MULT_GAUSS_EN
          res_re_d = part_q[0] - part_q[2];
          res_im_d = part_q[0] + part_q[1];
`else
          res_re_d = part_q[0] - part_q[1];
          res_im_d = part_q[2] + part_q[3];
`endif
          state_d = WAIT_RES;
        end
        WAIT_RES: begin
          if (res_ready) state_d = IDLE;
        end
        default: ;
      endcase
    end

    // Software reset overrides any accept/consume decided above
    if (sw_rst) begin
      state_d  = IDLE;
      idx_d    = '0;
      drain_d  = '0;
      res_re_d = '0;
      res_im_d = '0;
      pv_d     = '0;
      for (int unsigned i = 0; i < P; i++) part_d[i] = '0;
      for (int unsigned i = 0; i < MULT_LAT; i++) begin
        pp_d[i] = '0;
        pt_d[i] = '0;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      drain_q  <= '0;
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      res_re_q <= '0;
      res_im_q <= '0;
      pv_q     <= '0;
      for (int unsigned i = 0; i < P; i++) part_q[i] <= '0;
      for (int unsigned i = 0; i < MULT_LAT; i++) begin
        pp_q[i] <= '0;
        pt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      ar_q     <= ar_d;
      ai_q     <= ai_d;
      br_q     <= br_d;
      bi_q     <= bi_d;
      res_re_q <= res_re_d;
      res_im_q <= res_im_d;
      pv_q     <= pv_d;
      part_q   <= part_d;
      pp_q     <= pp_d;
      pt_q     <= pt_d;
    end
  end

endmodule

// File: tb/tb_cplx_mult_seq.sv
// Directed bench for cplx_mult_seq (DATA_W=8, MULT_LAT=1).
module tb_cplx_mult_seq;

  localparam int DW = 8;
  localparam int ML = 1;
`ifdef CPLX_MULT_GAUSS_EN
  localparam int P = 3;
`else
  localparam int P = 4;
`endif
  localparam int LAT = P + ML + 1;

  logic          clk = 1'b0;
  logic          rst, sw_rst, op_val, op_ready, res_val, res_ready, busy;
  logic [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic [2*DW:0] res_re, res_im;

  int n_tests = 0;
  int n_fail  = 0;

  cplx_mult_seq #(.DATA_W(DW), .MULT_LAT(ML)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst),
    .op_val(op_val), .op_ready(op_ready),
    .op_1_re(op_1_re), .op_1_im(op_1_im), .op_2_re(op_2_re), .op_2_im(op_2_im),
    .res_val(res_val), .res_ready(res_ready),
    .res_re(res_re), .res_im(res_im), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sre();
    return int'($signed(res_re));
  endfunction

  function automatic int sim();
    return int'($signed(res_im));
  endfunction

  task automatic drive(input logic [7:0] a_re, a_im, b_re, b_im);
    op_1_re = a_re;
    op_1_im = a_im;
    op_2_re = b_re;
    op_2_im = b_im;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_val && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a_re, a_im, b_re, b_im,
                        input int e_re, input int e_im);
    int cyc;
    drive(a_re, a_im, b_re, b_im);
    op_val    = 1'b1;
    res_ready = 1'b1;
    check({tag, "_rdy"}, int'(op_ready), 1);
    @(posedge clk); #1;
    op_val = 1'b0;
    check({tag, "_busy"}, int'(busy), 1);
    wait_res(cyc);
    check({tag, "_lat"}, cyc, LAT);
    check({tag, "_re"}, sre(), e_re);
    check({tag, "_im"}, sim(), e_im);
    @(posedge clk); #1;
    check({tag, "_pulse"}, int'(res_val), 0);
    check({tag, "_idle"}, int'(op_ready), 1);
  endtask

  initial begin
    int cyc, acc, rsp, gaps, pulses;
    logic will;
    logic [7:0] bv [8][4];
    int be_re [8];
    int be_im [8];
    int acc_cyc [8];

    rst = 1'b1; sw_rst = 1'b0; op_val = 1'b0; res_ready = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", int'(op_ready), 1);
    check("rst_res_val", int'(res_val), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_res_re", sre(), 0);
    check("rst_res_im", sim(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic and extreme products
    run_op("basic", 8'h03, 8'h04, 8'h01, 8'h02, -5, 10);
    run_op("ext1", 8'h80, 8'h80, 8'h80, 8'h80, 0, 32768);
    run_op("ext2", 8'h80, 8'h00, 8'h7F, 8'h80, -16256, 16384);
    run_op("ext3", 8'h7F, 8'h7F, 8'h7F, 8'h7F, 0, 32258);
    run_op("mix", 8'h05, 8'hF9, 8'hFE, 8'hFD, -31, -1);

    // Backpressure: result held, stray operands ignored
    drive(8'hFF, 8'hFF, 8'h01, 8'h00);
    op_val = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    op_val = 1'b0;
    wait_res(cyc);
    check("bp_lat", cyc, LAT);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_val%0d", i), int'(res_val), 1);
      check($sformatf("bp_re%0d", i), sre(), -1);
      check($sformatf("bp_im%0d", i), sim(), -1);
      check($sformatf("bp_rdy%0d", i), int'(op_ready), 0);
      op_val = 1'b1;
      drive(8'h11, 8'h22, 8'h33, 8'h44);
      @(posedge clk); #1;
    end
    op_val = 1'b0;
    check("bp_re_end", sre(), -1);
    check("bp_im_end", sim(), -1);
    res_ready = 1'b1;
    #1;
    check("bp_rdy_follow", int'(op_ready), 1);
    @(posedge clk); #1;
    check("bp_consumed", int'(res_val), 0);
    check("bp_idle_busy", int'(busy), 0);
    check("bp_idle_rdy", int'(op_ready), 1);

    // Back-to-back with op_val and res_ready held high
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) bv[k][j] = 8'($urandom_range(0, 255));
      be_re[k] = int'($signed(bv[k][0])) * int'($signed(bv[k][2]))
               - int'($signed(bv[k][1])) * int'($signed(bv[k][3]));
      be_im[k] = int'($signed(bv[k][0])) * int'($signed(bv[k][3]))
               + int'($signed(bv[k][1])) * int'($signed(bv[k][2]));
      acc_cyc[k] = 0;
    end
    acc = 0; rsp = 0; cyc = 0; gaps = 0;
    res_ready = 1'b1;
    drive(bv[0][0], bv[0][1], bv[0][2], bv[0][3]);
    op_val = 1'b1;
    while (rsp < 8 && cyc < 400) begin
      will = op_val && op_ready;
      if (acc > 0 && !busy) gaps++;
      if (res_val) begin
        check($sformatf("b2b_re%0d", rsp), sre(), be_re[rsp]);
        check($sformatf("b2b_im%0d", rsp), sim(), be_im[rsp]);
        check($sformatf("b2b_lat%0d", rsp), cyc - acc_cyc[rsp], LAT);
        rsp++;
      end
      @(posedge clk); #1;
      cyc++;
      if (will && acc < 8) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc < 8) drive(bv[acc][0], bv[acc][1], bv[acc][2], bv[acc][3]);
        else op_val = 1'b0;
      end
    end
    op_val = 1'b0;
    check("b2b_count", rsp, 8);
    check("b2b_gaps", gaps, 0);
    @(posedge clk); #1;
    check("b2b_idle", int'(busy), 0);

    // Abort during ISSUE index 2
    drive(8'h07, 8'h07, 8'h07, 8'h07);
    op_val = 1'b1;
    @(posedge clk); #1;
    op_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    check("abort_rdy", int'(op_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_re", sre(), 0);
    check("abort_im", sim(), 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (res_val) pulses++;
      @(posedge clk); #1;
    end
    check("abort_no_res", pulses, 0);

    // sw_rst beats a simultaneous op_val
    drive(8'h01, 8'h01, 8'h01, 8'h01);
    op_val = 1'b1; sw_rst = 1'b1;
    @(posedge clk); #1;
    op_val = 1'b0; sw_rst = 1'b0;
    check("swrst_no_accept", int'(busy), 0);

    run_op("post_abort", 8'h02, 8'hFF, 8'hFD, 8'h05, -1, 13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
